// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader and the register stage it feeds.
// Holds the FSM state encoding, default geometry and a small width helper.
package serial_word_loader_pkg;

  // Default geometry shared with the downstream write-enabled register stage.
  localparam int DEFAULT_WIDTH = 5;
  localparam int DEFAULT_WORDS = 4;

  // FSM state encoding, kept as plain constants for legacy tool compatibility.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_word_loader_mod_counter.sv
// Modulo-N up counter with synchronous clear and count enable.
// Used by the loader both as the bit counter and as the word counter.
module mod_counter
  import serial_word_loader_pkg::*;
#(
  parameter int MODULUS = 4,
  parameter int CW      = idxWidth(MODULUS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(MODULUS - 1);

  logic [CW-1:0] r_count;

  // Count modulo MODULUS; a clear takes priority over an enable in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (r_count == MAX_COUNT) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/serial_word_loader.sv
// Serial word loader: gathers a frame of WORDS words from a valid/ready bit
// stream, presents each completed word with a one-cycle write pulse, and
// pulses done after the last word. Every output comes from a register or is
// decoded from the state register, so no input reaches an output directly.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int WORDS     = DEFAULT_WORDS,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic                       i_ser_in,
  input  logic                       i_ser_valid,
  output logic                       o_ser_ready,
  output logic [WIDTH-1:0]           o_data_out,
  output logic                       o_write_en,
  output logic [idxWidth(WORDS)-1:0] o_word_idx,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int BITW = idxWidth(WIDTH + 1);
  localparam int IDXW = idxWidth(WORDS);

  localparam logic [BITW-1:0] LAST_BIT_IDX  = BITW'(WIDTH - 1);
  localparam logic [IDXW-1:0] LAST_WORD_IDX = IDXW'(WORDS - 1);

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] r_data_out;

  logic [BITW-1:0]  w_bit_cnt;
  logic [IDXW-1:0]  w_word_cnt;

  logic             w_in_idle;
  logic             w_in_shift;
  logic             w_in_write;
  logic             w_in_done;
  logic             w_start_accept;
  logic             w_xfer;
  logic             w_last_bit;
  logic             w_last_word;
  logic             w_bit_clear;
  logic             w_bit_enable;
  logic             w_word_clear;
  logic             w_word_enable;

  // State decodes used by both the control logic and the outputs.
  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_in_shift = (r_state == ST_SHIFT);
  assign w_in_write = (r_state == ST_WRITE);
  assign w_in_done  = (r_state == ST_DONE);

  // A bit only moves while shifting; start only counts while idle.
  assign w_start_accept = w_in_idle && i_start;
  assign w_xfer         = w_in_shift && i_ser_valid;
  assign w_last_bit     = w_xfer && (w_bit_cnt == LAST_BIT_IDX);
  assign w_last_word    = (w_word_cnt == LAST_WORD_IDX);

  // The bit counter restarts for each word; the word counter restarts per frame
  // and wraps back to zero as the frame finishes.
  assign w_bit_clear   = w_start_accept || w_in_write;
  assign w_bit_enable  = w_xfer;
  assign w_word_clear  = w_start_accept || w_in_done;
  assign w_word_enable = w_in_write && !w_last_word;

  mod_counter #(
    .MODULUS (WIDTH + 1),
    .CW      (BITW)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_bit_clear),
    .i_enable (w_bit_enable),
    .o_count  (w_bit_cnt)
  );

  mod_counter #(
    .MODULUS (WORDS),
    .CW      (IDXW)
  ) u_word_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_word_clear),
    .i_enable (w_word_enable),
    .o_count  (w_word_cnt)
  );

  // Next shift-register value: the incoming bit enters at the end opposite to
  // where the first bit of the word must finally sit.
  always_comb begin
    w_shift_next = r_shift;
    if (w_xfer) begin
      if (MSB_FIRST) begin
        w_shift_next = (r_shift << 1) | WIDTH'(i_ser_in);
      end else begin
        w_shift_next = (r_shift >> 1) | (WIDTH'(i_ser_in) << (WIDTH - 1));
      end
    end
  end

  // Shift register accumulates the word in progress; reset drops any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_xfer) begin
      r_shift <= w_shift_next;
    end
  end

  // Output word is captured as the final bit arrives and held until the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (w_last_bit) begin
      r_data_out <= w_shift_next;
    end
  end

  // Next-state selection for the IDLE -> SHIFT -> WRITE -> (SHIFT | DONE) flow.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_bit) begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_state_next = w_last_word ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign o_ser_ready = w_in_shift;
  assign o_write_en  = w_in_write;
  assign o_busy      = !w_in_idle;
  assign o_done      = w_in_done;
  assign o_data_out  = r_data_out;
  assign o_word_idx  = w_word_cnt;

endmodule

// File: tb/tb_serial_word_loader.sv
// Testbench for serial_word_loader. Three instances cover MSB-first single
// word, LSB-first single word and MSB-first four-word frames. Expected words
// are rebuilt from the bit stream with plain arithmetic.
module tb_serial_word_loader;

  localparam int W        = 5;
  localparam int NI       = 3;
  localparam int MAX_BITS = 20;

  logic                   clk;
  logic                   rst;
  logic [NI-1:0]          start;
  logic [NI-1:0]          serIn;
  logic [NI-1:0]          serValid;
  logic [NI-1:0]          serReady;
  logic [NI-1:0]          writeEn;
  logic [NI-1:0]          busy;
  logic [NI-1:0]          done;
  logic [NI-1:0][W-1:0]   dataOut;
  logic [0:0]             wIdx0;
  logic [0:0]             wIdx1;
  logic [1:0]             wIdx2;
  logic [NI-1:0][1:0]     wordIdx;

  int                     tests;
  int                     fails;
  logic [W-1:0]           lastW [NI];
  bit                     frameBits [MAX_BITS];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word index ports differ in width per instance; widen them for uniform checks.
  always_comb begin
    wordIdx[0] = {1'b0, wIdx0};
    wordIdx[1] = {1'b0, wIdx1};
    wordIdx[2] = wIdx2;
  end

  serial_word_loader #(.WIDTH(W), .WORDS(1), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .i_start(start[0]), .i_ser_in(serIn[0]),
    .i_ser_valid(serValid[0]), .o_ser_ready(serReady[0]), .o_data_out(dataOut[0]),
    .o_write_en(writeEn[0]), .o_word_idx(wIdx0), .o_busy(busy[0]), .o_done(done[0])
  );

  serial_word_loader #(.WIDTH(W), .WORDS(1), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start[1]), .i_ser_in(serIn[1]),
    .i_ser_valid(serValid[1]), .o_ser_ready(serReady[1]), .o_data_out(dataOut[1]),
    .o_write_en(writeEn[1]), .o_word_idx(wIdx1), .o_busy(busy[1]), .o_done(done[1])
  );

  serial_word_loader #(.WIDTH(W), .WORDS(4), .MSB_FIRST(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .i_start(start[2]), .i_ser_in(serIn[2]),
    .i_ser_valid(serValid[2]), .o_ser_ready(serReady[2]), .o_data_out(dataOut[2]),
    .o_write_en(writeEn[2]), .o_word_idx(wIdx2), .o_busy(busy[2]), .o_done(done[2])
  );

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit msbOf(input int inst);
    return inst != 1;
  endfunction

  // Reference model: the first bit of a word is worth 2^(W-1) when MSB first, 2^0 otherwise.
  function automatic logic [W-1:0] modelWord(input int base, input bit msb);
    int v;
    v = 0;
    for (int j = 0; j < W; j++) begin
      if (frameBits[base + j]) v += msb ? (1 << (W - 1 - j)) : (1 << j);
    end
    return W'(v);
  endfunction

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) frameBits[i] = ($urandom_range(0, 1) == 1);
  endtask

  // Emit a word's bits starting from its most significant bit.
  task automatic fillWord(input int k, input logic [W-1:0] value);
    for (int j = 0; j < W; j++) frameBits[k * W + j] = value[W - 1 - j];
  endtask

  // Drive one frame on an instance and check every cycle of it.
  // gapMode: 0 = valid always high, 1 = random gaps, 2 = one 3-cycle hole before bit 2.
  // abortAt >= 0 returns right after that many bits have transferred.
  task automatic applyStimulus(input int inst, input int nWords, input int gapMode,
                               input bit startNoise, input int abortAt);
    int bitIdx, wrCount, cycles, holeLeft, expCycles;
    bit seenDone, xfer;
    logic [W-1:0] expWord;
    bitIdx = 0; wrCount = 0; cycles = 0; seenDone = 0;
    holeLeft = (gapMode == 2) ? 3 : 0;
    start[inst] = 1'b1;
    serValid[inst] = 1'b0;
    serIn[inst] = ($urandom_range(0, 1) == 1);
    while (!seenDone && cycles < 500) begin
      xfer = serValid[inst] && serReady[inst];
      step();
      cycles++;
      if (xfer) bitIdx++;
      if (abortAt >= 0 && bitIdx == abortAt) break;
      start[inst] = startNoise && ($urandom_range(0, 1) == 1);
      tests++;
      if (busy[inst] !== 1'b1) begin
        fails++;
        $display("[TB] FAIL busy_in_frame inst%0d cycle %0d: got %b want 1", inst, cycles, busy[inst]);
      end
      if (writeEn[inst] === 1'b1) begin
        if (wrCount >= nWords) begin
          tests++; fails++;
          $display("[TB] FAIL extra_write inst%0d: write %0d, frame has %0d words", inst, wrCount, nWords);
        end else begin
          expWord = modelWord(wrCount * W, msbOf(inst));
          tests++;
          if (dataOut[inst] !== expWord) begin
            fails++;
            $display("[TB] FAIL data_out inst%0d word %0d: got %b want %b", inst, wrCount, dataOut[inst], expWord);
          end
          tests++;
          if (wordIdx[inst] !== 2'(wrCount)) begin
            fails++;
            $display("[TB] FAIL word_idx inst%0d: got %0d want %0d", inst, wordIdx[inst], wrCount);
          end
          tests++;
          if (serReady[inst] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ready_in_write inst%0d: got %b want 0", inst, serReady[inst]);
          end
          lastW[inst] = expWord;
        end
        wrCount++;
      end else begin
        tests++;
        if (dataOut[inst] !== lastW[inst]) begin
          fails++;
          $display("[TB] FAIL data_out_hold inst%0d cycle %0d: got %b want %b", inst, cycles, dataOut[inst], lastW[inst]);
        end
      end
      if (done[inst] === 1'b1) begin
        seenDone = 1;
        tests++;
        if (wrCount !== nWords) begin
          fails++;
          $display("[TB] FAIL write_count inst%0d: got %0d want %0d", inst, wrCount, nWords);
        end
        if (gapMode != 1) begin
          expCycles = nWords * (W + 1) + 1 + ((gapMode == 2) ? 3 : 0);
          tests++;
          if (cycles !== expCycles) begin
            fails++;
            $display("[TB] FAIL frame_latency inst%0d: got %0d want %0d", inst, cycles, expCycles);
          end
        end
      end
      if (bitIdx < nWords * W) begin
        if (gapMode == 2 && bitIdx == 2 && holeLeft > 0) begin
          holeLeft--;
          serValid[inst] = 1'b0;
          serIn[inst] = ($urandom_range(0, 1) == 1);
          tests++;
          if (serReady[inst] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ready_during_hole inst%0d: got %b want 1", inst, serReady[inst]);
          end
        end else if (gapMode == 1 && $urandom_range(0, 3) == 0) begin
          serValid[inst] = 1'b0;
          serIn[inst] = ($urandom_range(0, 1) == 1);
        end else begin
          serValid[inst] = 1'b1;
          serIn[inst] = frameBits[bitIdx];
        end
      end else begin
        serValid[inst] = 1'b0;
        serIn[inst] = 1'b0;
      end
    end
    if (abortAt < 0) begin
      if (!seenDone) begin
        tests++; fails++;
        $display("[TB] FAIL frame_timeout inst%0d: got no done want done within 500 cycles", inst);
      end else begin
        start[inst] = startNoise;
        serValid[inst] = 1'b0;
        step();
        tests++;
        if (busy[inst] !== 1'b0 || done[inst] !== 1'b0 || writeEn[inst] !== 1'b0) begin
          fails++;
          $display("[TB] FAIL after_done inst%0d: got busy=%b done=%b we=%b want 0 0 0", inst, busy[inst], done[inst], writeEn[inst]);
        end
        start[inst] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = '0; serValid = '0; serIn = '0;
    step();
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < NI; i++) begin
      tests++;
      if ({serReady[i], writeEn[i], busy[i], done[i]} !== 4'b0000) begin
        fails++;
        $display("[TB] FAIL reset_ctrl inst%0d: got rdy/we/busy/done=%b want 0000", i, {serReady[i], writeEn[i], busy[i], done[i]});
      end
      tests++;
      if (dataOut[i] !== '0 || wordIdx[i] !== 2'd0) begin
        fails++;
        $display("[TB] FAIL reset_data inst%0d: got data=%b idx=%0d want 0 0", i, dataOut[i], wordIdx[i]);
      end
      lastW[i] = '0;
    end
    serValid = '1;
    for (int c = 0; c < 6; c++) begin
      serIn = NI'($urandom_range(0, 7));
      step();
      tests++;
      if (writeEn !== '0 || busy !== '0) begin
        fails++;
        $display("[TB] FAIL idle_ignores_valid cycle %0d: got we=%b busy=%b want 0 0", c, writeEn, busy);
      end
    end
    serValid = '0;
  endtask

  task automatic test_msb_single();
    fillWord(0, 5'b10110);
    applyStimulus(0, 1, 0, 0, -1);
    tests++;
    if (dataOut[0] !== 5'b10110) begin
      fails++;
      $display("[TB] FAIL msb_word: got %b want 10110", dataOut[0]);
    end
    for (int r = 0; r < 3; r++) begin
      fillRandom(W);
      applyStimulus(0, 1, 1, 0, -1);
    end
  endtask

  task automatic test_lsb_gap();
    fillWord(0, 5'b10110);
    applyStimulus(1, 1, 2, 0, -1);
    tests++;
    if (dataOut[1] !== 5'b01101) begin
      fails++;
      $display("[TB] FAIL lsb_word: got %b want 01101", dataOut[1]);
    end
    for (int r = 0; r < 3; r++) begin
      fillRandom(W);
      applyStimulus(1, 1, 1, 0, -1);
    end
  endtask

  task automatic test_multi_word();
    for (int k = 0; k < 4; k++) fillWord(k, W'(1 << k));
    applyStimulus(2, 4, 0, 0, -1);
    for (int r = 0; r < 3; r++) begin
      fillRandom(4 * W);
      applyStimulus(2, 4, 1, 0, -1);
    end
  endtask

  task automatic test_reset_mid_frame();
    fillRandom(4 * W);
    applyStimulus(2, 4, 0, 0, 13);
    rst = 1'b1;
    start = '0;
    serValid = '0;
    step();
    rst = 1'b0;
    tests++;
    if ({serReady[2], writeEn[2], busy[2], done[2]} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL abort_ctrl: got rdy/we/busy/done=%b want 0000", {serReady[2], writeEn[2], busy[2], done[2]});
    end
    tests++;
    if (dataOut[2] !== '0 || wordIdx[2] !== 2'd0) begin
      fails++;
      $display("[TB] FAIL abort_data: got data=%b idx=%0d want 0 0", dataOut[2], wordIdx[2]);
    end
    for (int i = 0; i < NI; i++) lastW[i] = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (writeEn[2] !== 1'b0 || busy[2] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL abort_quiet cycle %0d: got we=%b busy=%b want 0 0", c, writeEn[2], busy[2]);
      end
    end
    fillRandom(4 * W);
    applyStimulus(2, 4, 1, 0, -1);
  endtask

  task automatic test_back_to_back();
    fillRandom(4 * W);
    applyStimulus(2, 4, 1, 1, -1);
    fillRandom(4 * W);
    applyStimulus(2, 4, 0, 1, -1);
    fillRandom(W);
    applyStimulus(0, 1, 0, 1, -1);
    fillRandom(W);
    applyStimulus(0, 1, 0, 1, -1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    start = '0;
    serIn = '0;
    serValid = '0;
    test_reset();
    test_msb_single();
    test_lsb_gap();
    test_multi_word();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
